rv_branch_pred: RTL and testbench
=================================

Name: rv_branch_pred

Overview:
- Fetch-side branch predictor that produces the prediction bit and predicted next PC carried down the pipeline alongside each instruction.
- Receives resolution updates back from the execute/ALU stage, which owns the other end of the branch_pred / pc_target interface.
- Direct-mapped branch target buffer with 2-bit saturating direction counters, plus performance counters.

Parameters:
IADDR_SPACE_BITS, 32, instruction address width (PC width)
ENTRIES, 16, BTB entry count; power of two, 2..256

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
i_flush  in  1  kill lookup result due next cycle
i_fetch_valid  in  1  lookup request this cycle
i_fetch_pc  in  IADDR_SPACE_BITS  PC to predict
o_pred_valid  out  1  prediction output valid
o_pred_pc  out  IADDR_SPACE_BITS  PC the prediction belongs to
o_pred_taken  out  1  predicted taken (becomes branch_pred downstream)
o_pred_target  out  IADDR_SPACE_BITS  predicted next PC
i_upd_valid  in  1  resolution update strobe
i_upd_pc  in  IADDR_SPACE_BITS  PC of the resolved instruction
i_upd_branch  in  1  resolved instruction is a conditional branch
i_upd_jump  in  1  resolved instruction is jal/jalr/mret
i_upd_taken  in  1  actual direction
i_upd_target  in  IADDR_SPACE_BITS  actual target (pc_target)
i_upd_pred  in  1  prediction that was made for this instruction
o_branch_cnt  out  32  resolved branches+jumps, saturating
o_mispred_cnt  out  32  direction mispredicts, saturating

Behaviour:
- Reset (async, i_reset_n=0): all entry valid bits cleared; all outputs 0 immediately, without a clock edge; both counters 0.
- Index = pc[log2(ENTRIES)+1:2]; tag = pc[IADDR_SPACE_BITS-1:log2(ENTRIES)+2]; pc[1:0] ignored.
- Entry contents: valid, tag, target, ctr[1:0], is_jump.
- Lookup, latency 1:
  - i_fetch_valid in cycle N -> o_pred_* registered at edge N+1; o_pred_pc = i_fetch_pc.
  - hit = valid & tag match.
  - o_pred_taken = hit & (is_jump | ctr[1]).
  - o_pred_target = taken ? entry target : i_fetch_pc+4, wrapping mod 2^IADDR_SPACE_BITS.
  - o_pred_valid = i_fetch_valid & !i_flush; taken/target/pc still update when not valid.
- Flush: i_flush in cycle N forces o_pred_valid=0 after edge N+1 and has priority over i_fetch_valid. Table is untouched by flush.
- Update, applied at the edge; ignored unless i_upd_valid & (i_upd_branch | i_upd_jump):
  - Hit: ctr saturating +1 if taken, -1 if not taken (bounds 0 and 3). If taken: target <= i_upd_target. is_jump <= i_upd_jump.
  - Miss & taken: allocate/overwrite slot. valid=1, tag, target, is_jump=i_upd_jump; ctr=3 if jump, else 2.
  - Miss & not taken: no change.
  - Jump updates with i_upd_taken=0 are treated as taken.
  - Both i_upd_branch and i_upd_jump set: treated as jump.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (read-before-write). The next lookup sees the new contents.
- Counters, per accepted update:
  - o_branch_cnt +1.
  - o_mispred_cnt +1 when i_upd_pred != effective taken.
  - Both saturate at 0xFFFFFFFF; registered, visible the cycle after the update.

Test Plan:
- Reset, then lookup 0x100 -> next cycle valid=1, taken=0, target=0x104, pc=0x100; counters 0.
- Branch update pc=0x100, taken, target=0x80, pred=0 -> lookup 0x100 gives taken=1, target=0x80; o_mispred_cnt=1, o_branch_cnt=1. Then two not-taken updates -> lookup gives taken=0, target=0x104.
- Saturation: four taken updates on 0x100, then one not-taken -> still taken=1. A second not-taken -> taken=0.
- Aliasing (ENTRIES=16): allocate 0x100 taken -> lookup 0x140 (same index, different tag) gives taken=0, target=0x144. Taken update at 0x140 evicts 0x100, so lookup 0x100 gives taken=0.
- JAL update pc=0x200, target=0x400, jump=1, taken=0 -> lookup 0x200 gives taken=1, target=0x400. A same-cycle lookup 0x200 during that update returns taken=0; the following lookup returns taken=1.
- Flush with fetch_valid asserted -> o_pred_valid=0 next cycle. Assert i_reset_n=0 mid-stream between clock edges -> all outputs 0 before the next edge, and lookup 0x100 after release misses.

Source files
------------

// File: rtl/rv_branch_pred.sv
// rv_branch_pred: direct-mapped BTB with 2-bit direction counters and
// branch/mispredict counters. The prediction appears one cycle after the lookup.
`default_nettype none

module rv_branch_pred #(
  parameter int IADDR_SPACE_BITS = 32,
  parameter int ENTRIES          = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic                        i_fetch_valid,
  input  logic [IADDR_SPACE_BITS-1:0] i_fetch_pc,
  output logic                        o_pred_valid,
  output logic [IADDR_SPACE_BITS-1:0] o_pred_pc,
  output logic                        o_pred_taken,
  output logic [IADDR_SPACE_BITS-1:0] o_pred_target,
  input  logic                        i_upd_valid,
  input  logic [IADDR_SPACE_BITS-1:0] i_upd_pc,
  input  logic                        i_upd_branch,
  input  logic                        i_upd_jump,
  input  logic                        i_upd_taken,
  input  logic [IADDR_SPACE_BITS-1:0] i_upd_target,
  input  logic                        i_upd_pred,
  output logic [31:0]                 o_branch_cnt,
  output logic [31:0]                 o_mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = IADDR_SPACE_BITS - IDX_W - 2;

  logic                        valid_q [ENTRIES];
  logic [TAG_W-1:0]            tag_q   [ENTRIES];
  logic [IADDR_SPACE_BITS-1:0] tgt_q   [ENTRIES];
  logic [1:0]                  ctr_q   [ENTRIES];
  logic                        jmp_q   [ENTRIES];

  logic                        pred_valid_q;
  logic [IADDR_SPACE_BITS-1:0] pred_pc_q;
  logic                        pred_taken_q;
  logic [IADDR_SPACE_BITS-1:0] pred_target_q;
  logic [31:0]                 branch_cnt_q, branch_cnt_d;
  logic [31:0]                 mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]            w_f_idx;
  logic [TAG_W-1:0]            w_f_tag;
  logic                        w_f_hit;
  logic                        w_f_taken;
  logic [IADDR_SPACE_BITS-1:0] w_f_target;

  logic [IDX_W-1:0]            w_u_idx;
  logic [TAG_W-1:0]            w_u_tag;
  logic                        w_u_acc;
  logic                        w_u_taken;
  logic                        w_u_hit;
  logic [1:0]                  w_ctr_nxt;
  logic                        w_unused;

  assign w_unused = ^{i_fetch_pc[1:0], i_upd_pc[1:0]};

  // Lookup reads the table as it stood before this edge's update.
  assign w_f_idx    = i_fetch_pc[IDX_W+1:2];
  assign w_f_tag    = i_fetch_pc[IADDR_SPACE_BITS-1:IDX_W+2];
  assign w_f_hit    = valid_q[w_f_idx] && (tag_q[w_f_idx] == w_f_tag);
  assign w_f_taken  = w_f_hit && (jmp_q[w_f_idx] || ctr_q[w_f_idx][1]);
  assign w_f_target = w_f_taken ? tgt_q[w_f_idx]
                                : i_fetch_pc + IADDR_SPACE_BITS'(4);

  // Jumps always count as taken, whatever the resolver reported.
  assign w_u_idx   = i_upd_pc[IDX_W+1:2];
  assign w_u_tag   = i_upd_pc[IADDR_SPACE_BITS-1:IDX_W+2];
  assign w_u_acc   = i_upd_valid && (i_upd_branch || i_upd_jump);
  assign w_u_taken = i_upd_jump || i_upd_taken;
  assign w_u_hit   = valid_q[w_u_idx] && (tag_q[w_u_idx] == w_u_tag);

  always_comb begin
    w_ctr_nxt = ctr_q[w_u_idx];
    if (w_u_taken) begin
      if (w_ctr_nxt != 2'd3) w_ctr_nxt = w_ctr_nxt + 2'd1;
    end else if (w_ctr_nxt != 2'd0) begin
      w_ctr_nxt = w_ctr_nxt - 2'd1;
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (w_u_acc) begin
      if (branch_cnt_q != 32'hFFFF_FFFF) branch_cnt_d = branch_cnt_q + 32'd1;
      if ((i_upd_pred != w_u_taken) && (mispred_cnt_q != 32'hFFFF_FFFF))
        mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'd0;
        jmp_q[i]   <= 1'b0;
      end
    end else if (w_u_acc) begin
      if (w_u_hit) begin
        ctr_q[w_u_idx] <= w_ctr_nxt;
        jmp_q[w_u_idx] <= i_upd_jump;
        if (w_u_taken) tgt_q[w_u_idx] <= i_upd_target;
      end else if (w_u_taken) begin
        valid_q[w_u_idx] <= 1'b1;
        tag_q[w_u_idx]   <= w_u_tag;
        tgt_q[w_u_idx]   <= i_upd_target;
        jmp_q[w_u_idx]   <= i_upd_jump;
        ctr_q[w_u_idx]   <= i_upd_jump ? 2'd3 : 2'd2;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pred_valid_q  <= 1'b0;
      pred_pc_q     <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pred_valid_q  <= i_fetch_valid && !i_flush;
      pred_pc_q     <= i_fetch_pc;
      pred_taken_q  <= w_f_taken;
      pred_target_q <= w_f_target;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_pred_valid  = pred_valid_q;
  assign o_pred_pc     = pred_pc_q;
  assign o_pred_taken  = pred_taken_q;
  assign o_pred_target = pred_target_q;
  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_rv_branch_pred.sv
// tb_rv_branch_pred: directed vectors with hand-computed expectations for rv_branch_pred.
`default_nettype none

module tb_rv_branch_pred;

  logic        clk;
  logic        rst_n;
  logic        flush, fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid, pred_taken;
  logic [31:0] pred_pc, pred_target;
  logic        upd_valid, upd_branch, upd_jump, upd_taken, upd_pred;
  logic [31:0] upd_pc, upd_target;
  logic [31:0] branch_cnt, mispred_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  rv_branch_pred #(.IADDR_SPACE_BITS(32), .ENTRIES(16)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_flush(flush),
    .i_fetch_valid(fetch_valid), .i_fetch_pc(fetch_pc),
    .o_pred_valid(pred_valid), .o_pred_pc(pred_pc),
    .o_pred_taken(pred_taken), .o_pred_target(pred_target),
    .i_upd_valid(upd_valid), .i_upd_pc(upd_pc), .i_upd_branch(upd_branch),
    .i_upd_jump(upd_jump), .i_upd_taken(upd_taken), .i_upd_target(upd_target),
    .i_upd_pred(upd_pred), .o_branch_cnt(branch_cnt), .o_mispred_cnt(mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    flush = 0; fetch_valid = 0; fetch_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_branch = 0; upd_jump = 0;
    upd_taken = 0; upd_target = 0; upd_pred = 0;
  endtask

  // One clock: apply inputs, take the edge, return 1ns later with inputs idle.
  task automatic cyc(input logic fv, input logic [31:0] fpc, input logic fl,
                     input logic uv, input logic [31:0] upc, input logic br,
                     input logic jp, input logic tk, input logic [31:0] tgt,
                     input logic pr);
    fetch_valid = fv; fetch_pc = fpc; flush = fl;
    upd_valid = uv; upd_pc = upc; upd_branch = br; upd_jump = jp;
    upd_taken = tk; upd_target = tgt; upd_pred = pr;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic lookup(input logic [31:0] pc);
    cyc(1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic br_upd(input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic pr);
    cyc(0, 0, 0, 1, pc, 1, 0, tk, tgt, pr);
  endtask

  task automatic expect_pred(input string tag, input logic v, input logic [31:0] pc,
                             input logic tk, input logic [31:0] tgt);
    check({tag, ".valid"},  {31'd0, pred_valid}, {31'd0, v});
    check({tag, ".pc"},     pred_pc, pc);
    check({tag, ".taken"},  {31'd0, pred_taken}, {31'd0, tk});
    check({tag, ".target"}, pred_target, tgt);
  endtask

  task automatic expect_cnt(input string tag, input int br, input int mp);
    check({tag, ".branch_cnt"},  branch_cnt, br);
    check({tag, ".mispred_cnt"}, mispred_cnt, mp);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #1;
    expect_pred("reset", 0, 0, 0, 0);
    expect_cnt("reset", 0, 0);
    @(posedge clk);
    #1 rst_n = 1;

    lookup(32'h100);
    expect_pred("cold", 1, 32'h100, 0, 32'h104);
    expect_cnt("cold", 0, 0);

    br_upd(32'h100, 1, 32'h80, 0);          // allocate, ctr=2
    expect_cnt("alloc", 1, 1);
    lookup(32'h100);
    expect_pred("alloc_hit", 1, 32'h100, 1, 32'h80);

    br_upd(32'h100, 0, 0, 1);               // ctr 1
    br_upd(32'h100, 0, 0, 1);               // ctr 0
    lookup(32'h100);
    expect_pred("weakened", 1, 32'h100, 0, 32'h104);
    expect_cnt("weakened", 3, 3);

    for (int i = 0; i < 4; i++) br_upd(32'h100, 1, 32'h80, 1);  // saturate at 3
    br_upd(32'h100, 0, 0, 1);               // ctr 2
    lookup(32'h100);
    expect_pred("sat_one_nt", 1, 32'h100, 1, 32'h80);
    br_upd(32'h100, 0, 0, 0);               // ctr 1
    lookup(32'h100);
    expect_pred("sat_two_nt", 1, 32'h100, 0, 32'h104);
    expect_cnt("sat", 9, 4);

    br_upd(32'h100, 1, 32'h80, 1);          // ctr 2
    lookup(32'h140);
    expect_pred("alias_miss", 1, 32'h140, 0, 32'h144);
    br_upd(32'h140, 1, 32'h300, 0);         // evicts 0x100
    lookup(32'h100);
    expect_pred("evicted", 1, 32'h100, 0, 32'h104);
    lookup(32'h140);
    expect_pred("alias_new", 1, 32'h140, 1, 32'h300);
    expect_cnt("alias", 11, 5);

    // JAL reported not-taken; same-cycle lookup must see old contents.
    cyc(1, 32'h200, 0, 1, 32'h200, 0, 1, 0, 32'h400, 0);
    expect_pred("jal_same_cycle", 1, 32'h200, 0, 32'h204);
    expect_cnt("jal", 12, 6);
    lookup(32'h200);
    expect_pred("jal_next", 1, 32'h200, 1, 32'h400);
    lookup(32'h140);
    expect_pred("jal_evicts", 1, 32'h140, 0, 32'h144);

    cyc(0, 0, 0, 1, 32'h300, 0, 0, 1, 32'h500, 0);  // neither branch nor jump
    expect_cnt("ignored_upd", 12, 6);
    lookup(32'h300);
    expect_pred("ignored_miss", 1, 32'h300, 0, 32'h304);

    cyc(1, 32'h200, 1, 0, 0, 0, 0, 0, 0, 0);
    expect_pred("flush", 0, 32'h200, 1, 32'h400);
    cyc(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_pred("no_fetch", 0, 32'h100, 0, 32'h104);

    lookup(32'hFFFF_FFFC);
    expect_pred("wrap", 1, 32'hFFFF_FFFC, 0, 32'h0);

    lookup(32'h200);
    expect_pred("pre_reset", 1, 32'h200, 1, 32'h400);
    #2 rst_n = 0;
    #1;
    expect_pred("async_reset", 0, 0, 0, 0);
    expect_cnt("async_reset", 0, 0);
    @(posedge clk);
    #1 rst_n = 1;
    lookup(32'h100);
    expect_pred("post_reset_100", 1, 32'h100, 0, 32'h104);
    lookup(32'h200);
    expect_pred("post_reset_200", 1, 32'h200, 0, 32'h204);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
